// File: rtl/branchpredict_satctr_if.sv
// ---------------------------------------------------------------------------
// branchpredict_satctr_if
// Groups the prediction request/response and the branch-resolution signals
// that pass between the fetch/execute stages and the saturating-counter
// predictor. The master modport is the pipeline side; the slave modport is
// the predictor.
// ---------------------------------------------------------------------------
interface branchpredict_satctr_if #(
   parameter int PCWIDTH   = 32,
   parameter int HISTWIDTH = 8
);

   // Prediction side (fetch stage)
   logic                 predict;
   logic [PCWIDTH-1:0]   pc_predict;
   logic                 prediction;
   logic [HISTWIDTH-1:0] pred_hist;
   logic                 ready;

   // Resolution side (branch-execute stage)
   logic                 result_rdy;
   logic                 result;
   logic [PCWIDTH-1:0]   pc_result;
   logic [HISTWIDTH-1:0] result_hist;

   modport master (
      output predict, pc_predict, result_rdy, result, pc_result, result_hist,
      input  prediction, pred_hist, ready
   );

   modport slave (
      input  predict, pc_predict, result_rdy, result, pc_result, result_hist,
      output prediction, pred_hist, ready
   );

endinterface

// File: rtl/branchpredict_satctr.sv
// ---------------------------------------------------------------------------
// branchpredict_satctr
// Branch prediction table of CTRWIDTH-bit saturating counters; the predicted
// direction is the counter MSB. After reset a sequential sweep writes the
// weakly-not-taken value into every entry, then ready rises. Predictions are
// a registered 1-cycle read with old-data semantics against a same-edge
// write. Resolved branches update the table through a 2-stage
// read-modify-write (U1 reads and captures, U2 writes), with the U2 result
// forwarded into a U1 read of the same entry so back-to-back updates stack.
//
// Optional feature macro: GSHARE_EN
//   When defined, a HISTWIDTH-bit global history register is shifted with
//   every resolved branch and XOR-ed into the table index; pred_hist carries
//   the history used for each prediction and result_hist returns it for the
//   update. When undefined, indexing is PC-only and pred_hist is 0.
// ---------------------------------------------------------------------------
module branchpredict_satctr #(
   parameter int PCWIDTH        = 32,
   parameter int LOG2TABLEDEPTH = 10,
   parameter int TABLEDEPTH     = 1024,
   parameter int CTRWIDTH       = 2,
   parameter int HISTWIDTH      = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   branchpredict_satctr_if.slave  bp
);

   // Elaboration-time parameter sanity checks
   if (TABLEDEPTH != (2 ** LOG2TABLEDEPTH)) begin : g_badDepth
      $error("branchpredict_satctr: TABLEDEPTH must equal 2**LOG2TABLEDEPTH");
   end
   if ((CTRWIDTH < 1) || (CTRWIDTH > 4)) begin : g_badCtrWidth
      $error("branchpredict_satctr: CTRWIDTH must be in 1..4");
   end
   if (HISTWIDTH > LOG2TABLEDEPTH) begin : g_badHistWidth
      $error("branchpredict_satctr: HISTWIDTH must not exceed LOG2TABLEDEPTH");
   end

   // Counter constants: saturation ceiling, weakly-not-taken init value, step
   localparam logic [CTRWIDTH-1:0]       CTR_MAX  = {CTRWIDTH{1'b1}};
   localparam logic [CTRWIDTH-1:0]       CTR_WNT  = CTRWIDTH'((2 ** (CTRWIDTH - 1)) - 1);
   localparam logic [CTRWIDTH-1:0]       CTR_ONE  = CTRWIDTH'(1);
   localparam logic [LOG2TABLEDEPTH-1:0] LAST_IDX = LOG2TABLEDEPTH'(TABLEDEPTH - 1);

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Controller state
   state_t                    r_state;
   state_t                    w_nextState;
   logic                      w_initDone;
   logic [LOG2TABLEDEPTH-1:0] r_initPtr;
   logic                      r_ready;

   // Counter table storage and its single write port
   logic [CTRWIDTH-1:0]       r_table [TABLEDEPTH];
   logic                      w_tableWe;
   logic [LOG2TABLEDEPTH-1:0] w_tableWAddr;
   logic [CTRWIDTH-1:0]       w_tableWData;

   // Prediction path
   logic [LOG2TABLEDEPTH-1:0] w_idxP;
   logic                      r_prediction;

   // Update pipeline: U1 capture registers feeding the U2 write
   logic [LOG2TABLEDEPTH-1:0] w_idxU;
   logic                      w_u1Accept;
   logic                      w_fwdHit;
   logic                      r_uValid;
   logic [LOG2TABLEDEPTH-1:0] r_uIdx;
   logic                      r_uResult;
   logic [CTRWIDTH-1:0]       r_uCtr;
   logic [CTRWIDTH-1:0]       w_satCtr;

   // Index bits of the PCs; the word-offset and upper bits are not used
   logic [LOG2TABLEDEPTH-1:0] w_pcIdxP;
   logic [LOG2TABLEDEPTH-1:0] w_pcIdxU;

   assign w_pcIdxP = bp.pc_predict[LOG2TABLEDEPTH+1:2];
   assign w_pcIdxU = bp.pc_result[LOG2TABLEDEPTH+1:2];

`ifdef GSHARE_EN
   // Global history register and the history captured with each prediction
   logic [HISTWIDTH-1:0] r_ghr;
   logic [HISTWIDTH-1:0] r_predHist;

   assign w_idxP = w_pcIdxP ^ LOG2TABLEDEPTH'(r_ghr);
   assign w_idxU = w_pcIdxU ^ LOG2TABLEDEPTH'(bp.result_hist);

   // History shifts in each resolved outcome at the U1 capture edge
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ghr <= '0;
      end else if (w_u1Accept) begin
         r_ghr <= HISTWIDTH'({r_ghr, bp.result});
      end
   end

   // History that accompanies the prediction, loaded under the same enable
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_predHist <= '0;
      end else if ((r_state == ST_RUN) && bp.predict) begin
         r_predHist <= r_ghr;
      end
   end

   assign bp.pred_hist = r_predHist;

   logic w_unusedPcBits;
   assign w_unusedPcBits = ^{bp.pc_predict[PCWIDTH-1:LOG2TABLEDEPTH+2], bp.pc_predict[1:0],
                             bp.pc_result[PCWIDTH-1:LOG2TABLEDEPTH+2], bp.pc_result[1:0]};
`else
   assign w_idxP       = w_pcIdxP;
   assign w_idxU       = w_pcIdxU;
   assign bp.pred_hist = '0;

   logic w_unusedPcBits;
   assign w_unusedPcBits = ^{bp.pc_predict[PCWIDTH-1:LOG2TABLEDEPTH+2], bp.pc_predict[1:0],
                             bp.pc_result[PCWIDTH-1:LOG2TABLEDEPTH+2], bp.pc_result[1:0],
                             bp.result_hist};
`endif

   // State register: reset always returns to the init sweep
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_INIT;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next state: leave INIT on the edge that writes the last table entry
   always_comb begin
      w_nextState = r_state;
      w_initDone  = 1'b0;
      case (r_state)
         ST_INIT: begin
            if (r_initPtr == LAST_IDX) begin
               w_nextState = ST_RUN;
               w_initDone  = 1'b1;
            end
         end
         ST_RUN: begin
            w_nextState = ST_RUN;
         end
         default: begin
            w_nextState = ST_INIT;
         end
      endcase
   end

   // Sweep pointer advances once per INIT cycle, wrapping to 0 at the end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_initPtr <= '0;
      end else if (r_state == ST_INIT) begin
         r_initPtr <= r_initPtr + LOG2TABLEDEPTH'(1);
      end
   end

   // Ready rises at the same edge as the final sweep write
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ready <= 1'b0;
      end else if (w_initDone) begin
         r_ready <= 1'b1;
      end
   end

   assign bp.ready = r_ready;

   // Table write port: the sweep owns it in INIT, the U2 stage in RUN
   always_comb begin
      w_tableWe    = 1'b0;
      w_tableWAddr = r_initPtr;
      w_tableWData = CTR_WNT;
      if (r_state == ST_INIT) begin
         w_tableWe = 1'b1;
      end else if (r_uValid) begin
         w_tableWe    = 1'b1;
         w_tableWAddr = r_uIdx;
         w_tableWData = w_satCtr;
      end
   end

   // Counter storage has no reset; the sweep establishes its contents
   always_ff @(posedge clk) begin
      if (w_tableWe) begin
         r_table[w_tableWAddr] <= w_tableWData;
      end
   end

   // Prediction register samples the pre-write counter MSB when enabled
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_prediction <= 1'b0;
      end else if ((r_state == ST_RUN) && bp.predict) begin
         r_prediction <= r_table[w_idxP][CTRWIDTH-1];
      end
   end

   assign bp.prediction = r_prediction;

   // U1 accepts one resolved branch per RUN cycle; a same-entry U2 write
   // in flight supplies the counter instead of the stale table value
   assign w_u1Accept = (r_state == ST_RUN) && bp.result_rdy;
   assign w_fwdHit   = r_uValid && (r_uIdx == w_idxU);

   // U1 capture: index, outcome and current counter value for the U2 write
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_uValid  <= 1'b0;
         r_uIdx    <= '0;
         r_uResult <= 1'b0;
         r_uCtr    <= '0;
      end else begin
         r_uValid <= w_u1Accept;
         if (w_u1Accept) begin
            r_uIdx    <= w_idxU;
            r_uResult <= bp.result;
            r_uCtr    <= w_fwdHit ? w_satCtr : r_table[w_idxU];
         end
      end
   end

   // U2 saturating step: count up on taken, down on not-taken, never wrap
   always_comb begin
      w_satCtr = r_uCtr;
      if (r_uResult) begin
         if (r_uCtr != CTR_MAX) begin
            w_satCtr = r_uCtr + CTR_ONE;
         end
      end else begin
         if (r_uCtr != '0) begin
            w_satCtr = r_uCtr - CTR_ONE;
         end
      end
   end

endmodule

// File: tb/tb_branchpredict_satctr.sv
// ---------------------------------------------------------------------------
// tb_branchpredict_satctr
// Self-checking bench for branchpredict_satctr with default parameters.
// Keeps its own counter-table model; expected predictions are queued when a
// predict is driven and compared after the response edge.
// ---------------------------------------------------------------------------
module tb_branchpredict_satctr;

   localparam int PCW   = 32;
   localparam int L2    = 10;
   localparam int DEPTH = 1024;
   localparam int CW    = 2;
   localparam int HW    = 8;
   localparam int CMAX  = (2 ** CW) - 1;
   localparam int WNT   = (2 ** (CW - 1)) - 1;

   typedef struct {
      logic          pred;
      logic [HW-1:0] hist;
   } exp_t;

   logic clk;
   logic reset;

   branchpredict_satctr_if #(.PCWIDTH(PCW), .HISTWIDTH(HW)) bp ();

   branchpredict_satctr #(
      .PCWIDTH(PCW),
      .LOG2TABLEDEPTH(L2),
      .TABLEDEPTH(DEPTH),
      .CTRWIDTH(CW),
      .HISTWIDTH(HW)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bp(bp)
   );

   int            checks;
   int            errors;
   int            model [DEPTH];
   logic [HW-1:0] ghrModel;
   exp_t          expQ [$];

   // Free-running clock, 10 time units per period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int idxOf(input logic [PCW-1:0] pc, input logic [HW-1:0] h);
      int i;
      i = int'(pc[L2+1:2]);
`ifdef GSHARE_EN
      i = i ^ int'(h);
`endif
      return i;
   endfunction

   function automatic logic msbOf(input int v);
      return logic'((v >> (CW - 1)) & 1);
   endfunction

   task automatic initModel();
      for (int i = 0; i < DEPTH; i++) model[i] = WNT;
      ghrModel = '0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Counts cycles until ready rises, bounded; returns -1 on expiry
   task automatic waitReady(output int n);
      n = 0;
      while (!bp.ready && n < 2000) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!bp.ready) n = -1;
   endtask

   // One resolved branch for a single cycle, mirrored into the model
   task automatic applyResult(input logic [PCW-1:0] pc, input logic taken, input logic [HW-1:0] h);
      int k;
      bp.result_rdy  = 1'b1;
      bp.pc_result   = pc;
      bp.result      = taken;
      bp.result_hist = h;
      @(posedge clk);
      #1;
      bp.result_rdy = 1'b0;
      k = idxOf(pc, h);
      if (taken) model[k] = (model[k] == CMAX) ? CMAX : model[k] + 1;
      else       model[k] = (model[k] == 0) ? 0 : model[k] - 1;
`ifdef GSHARE_EN
      ghrModel = HW'({ghrModel, taken});
`endif
   endtask

   // Pops one queued expectation and compares it with the DUT response
   task automatic checkOutput(input string name);
      exp_t e;
      if (expQ.size() == 0) begin
         errors++;
         checks++;
         $display("[TB] FAIL %s: scoreboard empty", name);
         return;
      end
      e = expQ.pop_front();
      checks++;
      if (bp.prediction !== e.pred) begin
         errors++;
         $display("[TB] FAIL %s prediction: got %b expected %b", name, bp.prediction, e.pred);
      end
      checks++;
      if (bp.pred_hist !== e.hist) begin
         errors++;
         $display("[TB] FAIL %s pred_hist: got %h expected %h", name, bp.pred_hist, e.hist);
      end
   endtask

   // Predict from the committed model state and check one cycle later
   task automatic applyPredict(input logic [PCW-1:0] pc, input string name);
      exp_t e;
      e.pred = msbOf(model[idxOf(pc, ghrModel)]);
      e.hist = ghrModel;
      expQ.push_back(e);
      bp.predict    = 1'b1;
      bp.pc_predict = pc;
      @(posedge clk);
      #1;
      bp.predict = 1'b0;
      checkOutput(name);
   endtask

   task automatic checkSweep(input int n, input string name);
      checks++;
      if (n !== DEPTH) begin
         errors++;
         $display("[TB] FAIL %s: ready after %0d cycles expected %0d", name, n, DEPTH);
      end
   endtask

   task automatic checkReadyLow(input string name);
      checks++;
      if (bp.ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL %s: ready got %b expected 0", name, bp.ready);
      end
   endtask

   // Reset values while reset is held
   task automatic test_reset();
      reset          = 1'b1;
      bp.predict     = 1'b0;
      bp.pc_predict  = '0;
      bp.result_rdy  = 1'b0;
      bp.result      = 1'b0;
      bp.pc_result   = '0;
      bp.result_hist = '0;
      idle(3);
      checkReadyLow("reset_ready");
      checks++;
      if (bp.prediction !== 1'b0 || bp.pred_hist !== '0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: prediction %b pred_hist %h expected 0 0", bp.prediction, bp.pred_hist);
      end
   endtask

   // Sweep length, inputs ignored during INIT, and cleared table afterwards
   task automatic test_init_sweep();
      int n;
      reset         = 1'b0;
      bp.predict    = 1'b1;
      bp.pc_predict = 32'h40;
      bp.result_rdy = 1'b1;
      bp.result     = 1'b1;
      bp.pc_result  = 32'h200;
      waitReady(n);
      bp.predict    = 1'b0;
      bp.result_rdy = 1'b0;
      checkSweep(n, "init_sweep");
      checks++;
      if (bp.prediction !== 1'b0) begin
         errors++;
         $display("[TB] FAIL init_hold: prediction got %b expected 0", bp.prediction);
      end
      initModel();
      applyPredict(32'h0, "init_pc0");
      applyPredict(32'hFFC, "init_pclast");
      applyPredict(32'h200, "init_ignored_result");
      applyPredict($urandom, "init_random");
   endtask

   // Counting up to saturation and back down to saturation at zero
   task automatic test_saturate();
      applyResult(32'h40, 1'b1, ghrModel);
      idle(1);
      applyPredict(32'h40, "sat_one_taken");
      for (int i = 0; i < 3; i++) applyResult(32'h40, 1'b1, ghrModel);
      idle(1);
      applyPredict(32'h40, "sat_top");
      applyResult(32'h40, 1'b0, ghrModel);
      idle(1);
      applyPredict(32'h40, "sat_top_minus1");
      applyResult(32'h40, 1'b0, ghrModel);
      applyResult(32'h40, 1'b0, ghrModel);
      idle(1);
      applyPredict(32'h40, "sat_zero");
      applyResult(32'h40, 1'b0, ghrModel);
      applyResult(32'h40, 1'b0, ghrModel);
      applyResult(32'h40, 1'b1, ghrModel);
      idle(1);
      applyPredict(32'h40, "sat_no_wrap");
   endtask

   // Consecutive updates to one entry must both land
   task automatic test_back_to_back();
      applyResult(32'h100, 1'b1, ghrModel);
      applyResult(32'h100, 1'b1, ghrModel);
      idle(1);
      applyPredict(32'h100, "b2b_taken");
      applyResult(32'h100, 1'b0, ghrModel);
      idle(1);
      applyPredict(32'h100, "b2b_then_nt");
   endtask

   // Prediction on the U2 write edge sees the pre-write counter
   task automatic test_old_data();
      int   ku;
      int   kp;
      int   oldVal;
      exp_t e;
      ku     = idxOf(32'h80, ghrModel);
      oldVal = model[ku];
      applyResult(32'h80, 1'b1, ghrModel);
      kp     = idxOf(32'h80, ghrModel);
      e.pred = msbOf((kp == ku) ? oldVal : model[kp]);
      e.hist = ghrModel;
      expQ.push_back(e);
      bp.predict    = 1'b1;
      bp.pc_predict = 32'h80;
      @(posedge clk);
      #1;
      bp.predict = 1'b0;
      checkOutput("old_data_same_edge");
      applyPredict(32'h80, "old_data_next");
   endtask

   // Reset mid-sweep restarts it; reset with an update pending drops it
   task automatic test_reset_midop();
      int n;
      reset = 1'b1;
      #1;
      checkReadyLow("midop_ready_drop");
      @(posedge clk);
      #1;
      reset = 1'b0;
      idle(500);
      reset = 1'b1;
      #1;
      checkReadyLow("midsweep_ready");
      @(posedge clk);
      #1;
      reset = 1'b0;
      waitReady(n);
      checkSweep(n, "midsweep_restart");
      initModel();
      bp.result_rdy  = 1'b1;
      bp.pc_result   = 32'h300;
      bp.result      = 1'b1;
      bp.result_hist = '0;
      @(posedge clk);
      #1;
      bp.result_rdy = 1'b0;
      reset         = 1'b1;
      #1;
      checkReadyLow("pending_ready");
      @(posedge clk);
      #1;
      reset = 1'b0;
      waitReady(n);
      checkSweep(n, "pending_restart");
      initModel();
      applyPredict(32'h300, "pending_dropped");
   endtask

`ifdef GSHARE_EN
   // History shifting, history-indexed read and history-indexed update
   task automatic test_gshare();
      int n;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      waitReady(n);
      checkSweep(n, "gshare_sweep");
      initModel();
      applyResult(32'h800, 1'b1, 8'h00);
      applyResult(32'h800, 1'b0, 8'h00);
      applyResult(32'h800, 1'b1, 8'h00);
      idle(1);
      applyPredict(32'h0, "gshare_entry5_read");
      checks++;
      if (bp.pred_hist !== 8'h05) begin
         errors++;
         $display("[TB] FAIL gshare_hist: got %h expected 05", bp.pred_hist);
      end
      applyResult(32'h0, 1'b1, 8'h05);
      idle(1);
      applyPredict(32'h38, "gshare_entry5_after");
      applyPredict(32'h2C, "gshare_entry0_after");
   endtask
`endif

   initial begin
      checks = 0;
      errors = 0;
      initModel();
      test_reset();
      test_init_sweep();
      test_saturate();
      test_back_to_back();
      test_old_data();
      test_reset_midop();
`ifdef GSHARE_EN
      test_gshare();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/branchpredict_satctr.md
Name: branchpredict_satctr

Overview:
Parametrised successor to the 1-bit branch prediction table. Each entry is a CTRWIDTH-bit saturating counter, and the prediction is the counter MSB. The table is cleared by a sequential init sweep after reset, and updates use a 2-stage read-modify-write. The block sits beside the scalar fetch stage and is resolved from the branch-execute stage.

Parameters:
- PCWIDTH, 32, PC width.
- LOG2TABLEDEPTH, 10, index bits (PC bits [LOG2TABLEDEPTH+1:2]).
- TABLEDEPTH, 1024, entries; must equal 2**LOG2TABLEDEPTH.
- CTRWIDTH, 2, counter bits; range 1..4.
- HISTWIDTH, 8, global history bits; must be <= LOG2TABLEDEPTH; used only with GSHARE_EN.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- predict  in  1  prediction read enable.
- pc_predict  in  PCWIDTH  PC to predict.
- prediction  out  1  1=taken, 0=not-taken; registered.
- pred_hist  out  HISTWIDTH  history used for this prediction; registered with prediction.
- ready  out  1  high once the init sweep is done.
- result_rdy  in  1  branch resolved this cycle.
- result  in  1  actual outcome, 1=taken.
- pc_result  in  PCWIDTH  PC of the resolved branch.
- result_hist  in  HISTWIDTH  pred_hist value returned with the resolved branch.

Behaviour:
Reset (async, active-high):
- Outputs: prediction=0, pred_hist=0, ready=0.
- Internal state: ghr=0, init_ptr=0, update pipeline valid=0, state=INIT.
- Reset asserted mid-operation discards any pending update and restarts the sweep.

INIT state:
- Each cycle writes WNT = 2**(CTRWIDTH-1)-1 (1 for CTRWIDTH=2; 0 for CTRWIDTH=1) to entry init_ptr, then increments init_ptr.
- After the write of entry TABLEDEPTH-1: state->RUN and ready=1 at that same edge. The sweep takes exactly TABLEDEPTH cycles after reset deasserts.
- predict and result_rdy are ignored; prediction and pred_hist hold 0.

RUN state, prediction:
- Index idx_p = pc_predict[LOG2TABLEDEPTH+1:2], XOR history when GSHARE_EN.
- If predict=1 at edge E: prediction <= MSB of ctr[idx_p] and pred_hist <= ghr. Latency is 1 cycle.
- If predict=0: prediction and pred_hist hold their values (clock enable).
- Mixed-port read-during-write uses OLD_DATA: the value captured at edge E ignores any write committed at edge E.

RUN state, update (2 stages):
- Stage U1 (edge with result_rdy=1): capture idx_u (from pc_result, XOR result_hist when GSHARE_EN) and result; set valid.
- Stage U2 (next edge): ctr[idx_u] <= sat(ctr[idx_u], result).
  - Taken: +1, saturating at 2**CTRWIDTH-1.
  - Not-taken: -1, saturating at 0.
- Accepts one result per cycle, fully pipelined.
- Back-to-back updates to the same index must both take effect (forward the U2 result into the next U2 read). Example: ctr=1 with two consecutive taken results -> 3.
- Simultaneous predict and update to the same index: the prediction sees the pre-write value.
- Widths: counter arithmetic is CTRWIDTH bits and never wraps.

Optional Feature:
GSHARE_EN:
- Defined:
  - A HISTWIDTH-bit global history register ghr is updated at each RUN result_rdy edge: ghr <= {ghr[HISTWIDTH-2:0], result}.
  - idx_p = PC index XOR {0, ghr}; idx_u = PC index XOR {0, result_hist}. Zero-extend history to LOG2TABLEDEPTH bits.
  - Update ordering: the ghr shift happens at the same edge as stage U1 capture; a prediction at that edge uses the old ghr.
- Undefined:
  - No ghr (reads 0); pred_hist is constant 0; result_hist is ignored; indexing is PC-only.

Test Plan:
1. Release reset, CTRWIDTH=2, TABLEDEPTH=1024 -> ready rises exactly 1024 cycles later; predict at any PC -> prediction=0.
2. One taken update at PC 0x40, then predict 0x40 -> 1. Three more taken, then one not-taken, then predict -> 1 (counter 3->2). Two further not-taken -> 0; further not-taken keep the counter at 0.
3. Two back-to-back taken results at PC 0x100 (ctr=1), then predict -> 1; a single not-taken then gives 1 (counter at 2, not 1).
4. predict at 0x80 on the same edge U2 writes 0x80 from 1->2 -> prediction=0 (old data); next predict -> 1.
5. Assert reset during the init sweep (cycle 500) and during a pending update -> ready drops, the sweep restarts from 0 and takes the full 1024 cycles, and the pending update is not applied.
6. GSHARE_EN, HISTWIDTH=8: shift in results 1,0,1 so ghr=0x05. Predict at PC 0x0 -> pred_hist=0x05 and entry 5 is read. A taken update with pc_result=0x0 and result_hist=0x05 increments entry 5, not entry 0.
